// File: rtl/avg_fetch_if.sv
// Fetch-side bus: byte-wide vector-memory read port, instruction handshake
// toward avg_decode, and the decoder's control-flow feedback.
interface avg_fetch_if;
    logic [15:0] mem_addr;
    logic [7:0]  mem_rdata;
    logic [31:0] inst;
    logic        inst_valid;
    logic        inst_ready;
    logic        jmp;
    logic        jsr;
    logic        ret;
    logic        halt;
    logic [15:0] jumpAddr;
    logic [2:0]  pcOffset;

    modport master (
        output mem_addr, inst, inst_valid,
        input  mem_rdata, inst_ready, jmp, jsr, ret, halt, jumpAddr, pcOffset
    );

    modport slave (
        input  mem_addr, inst, inst_valid,
        output mem_rdata, inst_ready, jmp, jsr, ret, halt, jumpAddr, pcOffset
    );
endinterface

// File: rtl/avg_fetch.sv
// AVG instruction fetch: assembles a 32-bit window from byte-wide memory,
// hands it to the decoder and follows jmp/jsr/ret/halt feedback.
module avg_fetch #(
    parameter int STACK_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] start_addr,
    avg_fetch_if.master bus,
    output logic        busy,
    output logic        halted,
    output logic        stack_err
);
    localparam int IDX_W = $clog2(STACK_DEPTH);
    localparam int SP_W  = IDX_W + 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_FETCH  = 2'd1;
    localparam logic [1:0] S_VALID  = 2'd2;
    localparam logic [1:0] S_HALTED = 2'd3;

    logic [1:0]      state;
    logic [2:0]      cnt;
    logic [15:0]     pc;
    logic [SP_W-1:0] sp;
    logic [15:0]     stack [STACK_DEPTH];
    logic [15:0]     addr_q;
    logic [31:0]     inst_q;

    logic [15:0]      fetch_addr;
    logic [15:0]      mem_addr_c;
    logic [15:0]      next_seq;
    logic             accept;
    logic             sp_full;
    logic             sp_empty;
    logic [IDX_W-1:0] push_idx;
    logic [IDX_W-1:0] pop_idx;

    assign fetch_addr = pc + 16'(cnt);
    // Address is driven live during the four request cycles, otherwise held.
    assign mem_addr_c = (state == S_FETCH && cnt != 3'd4) ? fetch_addr : addr_q;
    assign next_seq   = pc + {12'd0, bus.pcOffset, 1'b0};
    assign accept     = (state == S_VALID) && bus.inst_ready;
    assign sp_full    = (sp == SP_W'(STACK_DEPTH));
    assign sp_empty   = (sp == '0);
    assign push_idx   = sp[IDX_W-1:0];
    assign pop_idx    = IDX_W'(sp - SP_W'(1));

    assign bus.mem_addr   = mem_addr_c;
    assign bus.inst       = inst_q;
    assign bus.inst_valid = (state == S_VALID);
    assign busy           = (state == S_FETCH) || (state == S_VALID);
    assign halted         = (state == S_HALTED);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= 3'd0;
            pc        <= 16'd0;
            sp        <= '0;
            stack_err <= 1'b0;
            addr_q    <= 16'd0;
            inst_q    <= 32'd0;
            for (int i = 0; i < STACK_DEPTH; i++) stack[i] <= 16'd0;
        end else begin
            case (state)
                S_IDLE, S_HALTED: begin
                    cnt <= 3'd0;
                    if (start) begin
                        pc        <= start_addr;
                        sp        <= '0;
                        stack_err <= 1'b0;
                        state     <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    addr_q <= mem_addr_c;
                    // Read data lags the address by one cycle, hence byte cnt-1.
                    case (cnt)
                        3'd1:    inst_q[31:24] <= bus.mem_rdata;
                        3'd2:    inst_q[23:16] <= bus.mem_rdata;
                        3'd3:    inst_q[15:8]  <= bus.mem_rdata;
                        3'd4:    inst_q[7:0]   <= bus.mem_rdata;
                        default: ;
                    endcase
                    if (cnt == 3'd4) begin
                        cnt   <= 3'd0;
                        state <= S_VALID;
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
                S_VALID: begin
                    if (accept) begin
                        if (bus.halt) begin
                            state <= S_HALTED;
                        end else if (bus.ret) begin
                            if (sp_empty) begin
                                stack_err <= 1'b1;
                                state     <= S_HALTED;
                            end else begin
                                pc    <= stack[pop_idx];
                                sp    <= sp - SP_W'(1);
                                state <= S_FETCH;
                            end
                        end else if (bus.jmp && bus.jsr) begin
                            if (sp_full) begin
                                stack_err <= 1'b1;
                                state     <= S_HALTED;
                            end else begin
                                stack[push_idx] <= next_seq;
                                sp              <= sp + SP_W'(1);
                                pc              <= bus.jumpAddr;
                                state           <= S_FETCH;
                            end
                        end else if (bus.jmp) begin
                            pc    <= bus.jumpAddr;
                            state <= S_FETCH;
                        end else begin
                            pc    <= next_seq;
                            state <= S_FETCH;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_avg_fetch.sv
// Self-checking bench for avg_fetch: byte memory model, reference PC/stack
// model and a queue of expected instruction windows.
module tb_avg_fetch;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] start_addr;
    logic        busy, halted, stack_err;

    avg_fetch_if bus ();

    avg_fetch #(.STACK_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .start(start), .start_addr(start_addr),
        .bus(bus), .busy(busy), .halted(halted), .stack_err(stack_err)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [0:65535];
    always @(posedge clk) bus.mem_rdata <= mem[bus.mem_addr];

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    logic [31:0] exp_q [$];
    logic [31:0] last_exp;

    logic [15:0] m_pc;
    int          m_sp;
    logic [15:0] m_stack [DEPTH];
    logic        m_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_inst(input logic [15:0] a);
        logic [15:0] a1, a2, a3;
        a1 = a + 16'd1;
        a2 = a + 16'd2;
        a3 = a + 16'd3;
        return {mem[a], mem[a1], mem[a2], mem[a3]};
    endfunction

    // Entered on the negedge of FETCH cycle 0.
    task automatic run_fetch();
        logic [15:0] ea;
        int n;
        check("busy_fetch", busy, 1);
        for (int i = 0; i < 4; i++) begin
            ea = m_pc + 16'(i);
            check($sformatf("addr%0d", i), bus.mem_addr, ea);
            if (i < 3) @(negedge clk);
        end
        @(negedge clk);
        check("valid_c4", bus.inst_valid, 0);
        @(negedge clk);
        check("valid_lat", bus.inst_valid, 1);
        n = 0;
        while (!bus.inst_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() > 0) begin
            last_exp = exp_q.pop_front();
            check("inst", bus.inst, last_exp);
        end
    endtask

    task automatic do_start(input logic [15:0] a, input bit fetch);
        m_pc  = a;
        m_sp  = 0;
        m_err = 1'b0;
        if (fetch) exp_q.push_back(exp_inst(a));
        start      = 1'b1;
        start_addr = a;
        @(negedge clk);
        start = 1'b0;
        if (fetch) run_fetch();
    endtask

    // Called on a negedge while inst_valid is high.
    task automatic step(input bit j, input bit js, input bit r, input bit h,
                        input logic [15:0] ja, input logic [2:0] off);
        logic [15:0] seq;
        bit fetch;
        seq   = m_pc + {12'd0, off, 1'b0};
        fetch = 1'b1;
        if (h) fetch = 1'b0;
        else if (r) begin
            if (m_sp == 0) begin m_err = 1'b1; fetch = 1'b0; end
            else begin m_sp--; m_pc = m_stack[m_sp]; end
        end else if (j && js) begin
            if (m_sp == DEPTH) begin m_err = 1'b1; fetch = 1'b0; end
            else begin m_stack[m_sp] = seq; m_sp++; m_pc = ja; end
        end else if (j) m_pc = ja;
        else m_pc = seq;
        if (fetch) exp_q.push_back(exp_inst(m_pc));
        bus.inst_ready = 1'b1;
        bus.jmp = j; bus.jsr = js; bus.ret = r; bus.halt = h;
        bus.jumpAddr = ja; bus.pcOffset = off;
        @(negedge clk);
        bus.inst_ready = 1'b0;
        bus.jmp = 1'b0; bus.jsr = 1'b0; bus.ret = 1'b0; bus.halt = 1'b0;
        check("valid_drop", bus.inst_valid, 0);
        if (fetch) run_fetch();
        else begin
            check("halted", halted, 1);
            check("busy_halt", busy, 0);
            check("stack_err", stack_err, m_err);
        end
    endtask

    task automatic check_reset_state();
        check("rst_mem_addr", bus.mem_addr, 0);
        check("rst_inst", bus.inst, 0);
        check("rst_valid", bus.inst_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_halted", halted, 0);
        check("rst_stack_err", stack_err, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'(i * 37 + (i >> 8) + 5);
        mem[0] = 8'hA0; mem[1] = 8'h00; mem[2] = 8'h12; mem[3] = 8'h34;
        rst = 1'b1; start = 1'b0; start_addr = 16'd0;
        bus.inst_ready = 1'b0; bus.jmp = 1'b0; bus.jsr = 1'b0; bus.ret = 1'b0;
        bus.halt = 1'b0; bus.jumpAddr = 16'd0; bus.pcOffset = 3'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_reset_state();

        // T1 basic fetch
        do_start(16'h0000, 1'b1);
        check("t1_inst", bus.inst, 32'hA0001234);
        // T2 jump then 1-word advance
        step(1, 0, 0, 0, 16'h0010, 3'd0);
        step(0, 0, 0, 0, 16'h0000, 3'd1);
        // T3 stall
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("stall_valid", bus.inst_valid, 1);
            check("stall_inst", bus.inst, last_exp);
            check("stall_addr", bus.mem_addr, m_pc + 16'd3);
        end
        // pcOffset 0 refetches same pc
        step(0, 0, 0, 0, 16'h0000, 3'd0);
        // T4 call/return, then underflow
        step(1, 0, 0, 0, 16'h0040, 3'd0);
        step(1, 1, 0, 0, 16'h0200, 3'd1);
        step(0, 0, 1, 0, 16'h0000, 3'd0);
        check("t4_ret_pc", bus.mem_addr, 16'h0045);
        step(0, 0, 1, 0, 16'h0000, 3'd0);
        // T5 overflow on DEPTH+1 nested calls
        do_start(16'h0100, 1'b1);
        check("t5_err_cleared", stack_err, 0);
        for (int k = 0; k <= DEPTH; k++)
            step(1, 1, 0, 0, 16'h0100 + 16'(32 * (k + 1)), 3'd2);
        check("t5_overflow", stack_err, 1);
        // halt keeps mem_addr frozen
        do_start(16'h0500, 1'b1);
        step(0, 0, 0, 1, 16'h0000, 3'd1);
        check("halt_addr_hold", bus.mem_addr, 16'h0503);
        // T6 reset mid-fetch, then wrap-around fetch
        do_start(16'h0300, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_state();
        do_start(16'hFFFE, 1'b1);
        step(0, 0, 0, 0, 16'h0000, 3'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
